// File: rtl/code_transmitter.sv
// Framed serializer: start bit, DATA_WIDTH data bits MSB first, GAP_BITS idle bits.
// A one-entry holding buffer lets the next word queue so frames can run back-to-back.
`timescale 1ns/1ps
module code_transmitter #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 1,
    parameter int GAP_BITS     = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  io_output,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int BIT_MAX = (DATA_WIDTH > GAP_BITS) ? DATA_WIDTH : GAP_BITS;
    localparam int BCW     = (BIT_MAX > 1) ? $clog2(BIT_MAX) : 1;
    localparam int CCW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_WIDTH - 1);
    localparam logic [BCW-1:0] GAP_LAST  = BCW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
    localparam logic [CCW-1:0] CLK_LAST  = CCW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, GAP} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  hold_valid_q, hold_valid_d;
    logic [CCW-1:0]        clk_cnt_q, clk_cnt_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                  io_q, io_d;
    logic                  done_q, done_d;
    logic                  accept;
    logic                  period_end;
    logic                  load;
    logic                  eof;

    assign in_ready   = !hold_valid_q;
    assign accept     = in_valid && !hold_valid_q;
    // With CLKS_PER_BIT=1 CLK_LAST is 0 and every cycle closes a bit period.
    assign period_end = (clk_cnt_q == CLK_LAST);
    assign io_output  = io_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = done_q;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        io_d      = io_q;
        done_d    = 1'b0;
        load      = 1'b0;
        eof       = 1'b0;

        if (state_q != IDLE) begin
            clk_cnt_d = period_end ? '0 : clk_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (hold_valid_q) begin
                    load = 1'b1;
                end
            end
            START: begin
                if (period_end) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    io_d      = shift_q[DATA_WIDTH-1];
                end
            end
            DATA: begin
                if (period_end) begin
                    if (bit_cnt_q == DATA_LAST) begin
                        if (GAP_BITS > 0) begin
                            state_d   = GAP;
                            bit_cnt_d = '0;
                            io_d      = 1'b0;
                        end else begin
                            eof = 1'b1;
                        end
                    end else begin
                        shift_d   = shift_q << 1;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        io_d      = shift_q[DATA_WIDTH-2];
                    end
                end
            end
            GAP: begin
                if (period_end) begin
                    if (bit_cnt_q == GAP_LAST) begin
                        eof = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A queued word at end-of-frame starts the next frame with no idle cycle.
        if (eof) begin
            done_d = 1'b1;
            if (hold_valid_q) begin
                load = 1'b1;
            end else begin
                state_d = IDLE;
                io_d    = 1'b0;
            end
        end

        if (load) begin
            state_d   = START;
            shift_d   = hold_q;
            io_d      = 1'b1;
            clk_cnt_d = '0;
        end
    end

    always_comb begin
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        if (load) begin
            hold_valid_d = 1'b0;
        end
        if (accept) begin
            hold_d       = in_data;
            hold_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            hold_valid_q <= 1'b0;
            clk_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            io_q         <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_valid_q <= hold_valid_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            io_q         <= io_d;
            done_q       <= done_d;
        end
    end

    // Data registers are qualified by state/hold_valid, so they need no reset.
    always_ff @(posedge clock) begin
        hold_q  <= hold_d;
        shift_q <= shift_d;
    end

endmodule
